dmem_port_arbiter: RTL and testbench

Shares one port of a per-PE data RAM between the RS5 core and the PE DMA engine, so each PE needs a single-port D_MEM instead of the current dual-port macro. The block grants one requester per cycle, with CPU priority by default, a DMA burst lock, and starvation guards in both directions. It routes 1-cycle-latency read data back to the requester that issued the read. It is instantiated once per PE, between the core/DMA and D_MEM.

---
 rtl/dmem_port_arbiter_pkg.sv | 20 ++
 rtl/dmem_port_arbiter_if.sv | 51 +++++
 rtl/dmem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared types and default tuning for the D_MEM arbiter.
// No ports; provides arb_state_t, rd_owner_t and default limits.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_CPU,
    S_DMA_LOCK,
    S_CPU_SLOT
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    CPU,
    DMA
  } rd_owner_t;

  localparam int DMEM_ARB_MAX_WAIT  = 8;
  localparam int DMEM_ARB_BURST_MAX = 16;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: CPU, DMA and RAM bus bundle around the D_MEM arbiter.
// slave = arbiter side, master = core/DMA/RAM side.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W     = 24,
  parameter int MEM_ADDR_W = 16
);

  logic                  cpu_req_i;
  logic [3:0]            cpu_we_i;
  logic [ADDR_W-1:0]     cpu_addr_i;
  logic [31:0]           cpu_data_i;
  logic                  cpu_gnt_o;
  logic                  cpu_rvalid_o;
  logic [31:0]           cpu_rdata_o;

  logic                  dma_req_i;
  logic                  dma_burst_i;
  logic [3:0]            dma_we_i;
  logic [ADDR_W-1:0]     dma_addr_i;
  logic [31:0]           dma_data_i;
  logic                  dma_gnt_o;
  logic                  dma_rvalid_o;
  logic [31:0]           dma_rdata_o;

  logic                  mem_en_o;
  logic [3:0]            mem_we_o;
  logic [MEM_ADDR_W-1:0] mem_addr_o;
  logic [31:0]           mem_data_o;
  logic [31:0]           mem_data_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
    input  dma_req_i, dma_burst_i, dma_we_i,
    input  dma_addr_i, dma_data_i,
    output dma_gnt_o, dma_rvalid_o, dma_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_data_o,
    input  mem_data_i
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
    output dma_req_i, dma_burst_i, dma_we_i,
    output dma_addr_i, dma_data_i,
    input  dma_gnt_o, dma_rvalid_o, dma_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_data_o,
    output mem_data_i
  );

endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port D_MEM between the core and PE DMA.
// Ports: clk_i, rst_i (sync, active high), bus (dmem_port_arbiter_if.slave).
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int MEM_ADDR_W = 16,
  parameter int MAX_WAIT   = DMEM_ARB_MAX_WAIT,
  parameter int BURST_MAX  = DMEM_ARB_BURST_MAX
) (
  input logic clk_i,
  input logic rst_i,
  dmem_port_arbiter_if.slave bus
);

  localparam int AW = (MEM_ADDR_W < ADDR_W) ? MEM_ADDR_W : ADDR_W;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [WW-1:0] WAIT_TOP = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

  arb_state_t      state_q, state_d;
  rd_owner_t       owner_q, owner_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [BW-1:0]   burst_q, burst_d;

  logic dma_first;
  logic cpu_gnt;
  logic dma_gnt;
  logic cpu_rd;
  logic dma_rd;

  always_comb begin
    dma_first = 1'b0;
    unique case (state_q)
      S_CPU:      dma_first = (wait_q == WAIT_TOP);
      S_DMA_LOCK: dma_first = 1'b1;
      S_CPU_SLOT: dma_first = 1'b0;
      default:    dma_first = 1'b0;
    endcase
  end

  // Work-conserving: the loser only loses when the winner asks.
  assign cpu_gnt = !rst_i && bus.cpu_req_i
                   && !(dma_first && bus.dma_req_i);
  assign dma_gnt = !rst_i && bus.dma_req_i && !cpu_gnt;

  assign cpu_rd = cpu_gnt && (bus.cpu_we_i == 4'b0000);
  assign dma_rd = dma_gnt && (bus.dma_we_i == 4'b0000);

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    wait_d  = '0;
    owner_d = NONE;

    if (bus.dma_req_i && !dma_gnt)
      wait_d = (wait_q == WAIT_TOP) ? wait_q : wait_q + 1'b1;

    unique case (1'b1)
      cpu_rd:  owner_d = CPU;
      dma_rd:  owner_d = DMA;
      default: owner_d = NONE;
    endcase

    unique case (state_q)
      S_CPU: begin
        burst_d = '0;
        if (dma_gnt && bus.dma_burst_i) begin
          state_d = S_DMA_LOCK;
          burst_d = BW'(1);
        end
      end
      S_DMA_LOCK: begin
        // Withdrawal wins over lock expiry.
        if (!bus.dma_req_i || !bus.dma_burst_i) begin
          state_d = S_CPU;
          burst_d = '0;
        end else if (dma_gnt && burst_q >= BURST_LAST) begin
          state_d = S_CPU_SLOT;
          burst_d = '0;
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end
      S_CPU_SLOT: begin
        if (bus.dma_req_i && bus.dma_burst_i) begin
          state_d = S_DMA_LOCK;
          burst_d = dma_gnt ? BW'(1) : '0;
        end else begin
          state_d = S_CPU;
          burst_d = '0;
        end
      end
      default: begin
        state_d = S_CPU;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_CPU;
      owner_q <= NONE;
      wait_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
    end
  end

  assign bus.cpu_gnt_o = cpu_gnt;
  assign bus.dma_gnt_o = dma_gnt;
  assign bus.mem_en_o  = cpu_gnt | dma_gnt;

  always_comb begin
    bus.mem_we_o   = '0;
    bus.mem_addr_o = '0;
    bus.mem_data_o = '0;
    unique case (1'b1)
      cpu_gnt: begin
        bus.mem_we_o   = bus.cpu_we_i;
        bus.mem_addr_o = MEM_ADDR_W'(bus.cpu_addr_i[AW-1:0]);
        bus.mem_data_o = bus.cpu_data_i;
      end
      dma_gnt: begin
        bus.mem_we_o   = bus.dma_we_i;
        bus.mem_addr_o = MEM_ADDR_W'(bus.dma_addr_i[AW-1:0]);
        bus.mem_data_o = bus.dma_data_i;
      end
      default: begin
        bus.mem_we_o   = '0;
        bus.mem_addr_o = '0;
        bus.mem_data_o = '0;
      end
    endcase
  end

  assign bus.cpu_rvalid_o = !rst_i && (owner_q == CPU);
  assign bus.dma_rvalid_o = !rst_i && (owner_q == DMA);
  assign bus.cpu_rdata_o  = rst_i ? 32'h0 : bus.mem_data_i;
  assign bus.dma_rdata_o  = rst_i ? 32'h0 : bus.mem_data_i;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed plus random checks of dmem_port_arbiter.
// Drives the bus interface and compares every cycle against a behavioural model.
module tb_dmem_port_arbiter;

  localparam int MAX_WAIT  = 8;
  localparam int BURST_MAX = 16;

  logic clk;
  logic rst;

  dmem_port_arbiter_if #(.ADDR_W(24), .MEM_ADDR_W(16)) bus ();

  dmem_port_arbiter #(
    .ADDR_W(24),
    .MEM_ADDR_W(16),
    .MAX_WAIT(MAX_WAIT),
    .BURST_MAX(BURST_MAX)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int failed;

  // Model: waited cycles, grants in the current lock, lock/slot flags,
  // and who gets read data next cycle (0 none, 1 cpu, 2 dma).
  int m_wait;
  int m_run;
  bit m_lock;
  bit m_slot;
  int m_rd;

  logic        s_cgnt, s_dgnt, s_crv, s_drv;
  logic [31:0] s_crdata;
  logic [3:0]  s_we;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit          dfirst;
    logic        ec, ed;
    logic [3:0]  ewe;
    logic [15:0] ead;
    logic [31:0] edt;
    @(negedge clk);
    ec = 1'b0;
    ed = 1'b0;
    if (!rst) begin
      dfirst = m_lock || (!m_slot && m_wait == MAX_WAIT);
      ec = bus.cpu_req_i && !(dfirst && bus.dma_req_i);
      ed = bus.dma_req_i && !ec;
    end
    ewe = ec ? bus.cpu_we_i : ed ? bus.dma_we_i : 4'h0;
    ead = ec ? bus.cpu_addr_i[15:0] : ed ? bus.dma_addr_i[15:0] : 16'h0;
    edt = ec ? bus.cpu_data_i : ed ? bus.dma_data_i : 32'h0;
    chk("cpu_gnt", {31'b0, bus.cpu_gnt_o}, {31'b0, ec});
    chk("dma_gnt", {31'b0, bus.dma_gnt_o}, {31'b0, ed});
    chk("mem_en", {31'b0, bus.mem_en_o}, {31'b0, ec | ed});
    chk("mem_we", {28'b0, bus.mem_we_o}, {28'b0, ewe});
    chk("mem_addr", {16'b0, bus.mem_addr_o}, {16'b0, ead});
    chk("mem_data", bus.mem_data_o, edt);
    chk("cpu_rvalid", {31'b0, bus.cpu_rvalid_o},
        {31'b0, !rst && m_rd == 1});
    chk("dma_rvalid", {31'b0, bus.dma_rvalid_o},
        {31'b0, !rst && m_rd == 2});
    if (rst) begin
      chk("cpu_rdata_rst", bus.cpu_rdata_o, 32'h0);
      chk("dma_rdata_rst", bus.dma_rdata_o, 32'h0);
    end else if (m_rd == 1) begin
      chk("cpu_rdata", bus.cpu_rdata_o, bus.mem_data_i);
    end else if (m_rd == 2) begin
      chk("dma_rdata", bus.dma_rdata_o, bus.mem_data_i);
    end
    s_cgnt   = bus.cpu_gnt_o;
    s_dgnt   = bus.dma_gnt_o;
    s_crv    = bus.cpu_rvalid_o;
    s_drv    = bus.dma_rvalid_o;
    s_crdata = bus.cpu_rdata_o;
    s_we     = bus.mem_we_o;

    if (rst) begin
      m_wait = 0;
      m_run  = 0;
      m_lock = 0;
      m_slot = 0;
      m_rd   = 0;
    end else begin
      if (bus.dma_req_i && !ed)
        m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else
        m_wait = 0;
      if (ec && bus.cpu_we_i == 4'h0)
        m_rd = 1;
      else if (ed && bus.dma_we_i == 4'h0)
        m_rd = 2;
      else
        m_rd = 0;
      if (m_slot) begin
        m_slot = 0;
        m_lock = bus.dma_req_i && bus.dma_burst_i;
        m_run  = (m_lock && ed) ? 1 : 0;
      end else if (m_lock) begin
        if (!bus.dma_req_i || !bus.dma_burst_i) begin
          m_lock = 0;
          m_run  = 0;
        end else begin
          if (ed) m_run++;
          if (m_run >= BURST_MAX) begin
            m_lock = 0;
            m_slot = 1;
            m_run  = 0;
          end
        end
      end else if (ed && bus.dma_burst_i) begin
        m_lock = 1;
        m_run  = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_req_i   = 1'b0;
    bus.cpu_we_i    = 4'h0;
    bus.cpu_addr_i  = '0;
    bus.cpu_data_i  = '0;
    bus.dma_req_i   = 1'b0;
    bus.dma_burst_i = 1'b0;
    bus.dma_we_i    = 4'h0;
    bus.dma_addr_i  = '0;
    bus.dma_data_i  = '0;
    bus.mem_data_i  = '0;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    m_wait = 0;
    m_run  = 0;
    m_lock = 0;
    m_slot = 0;
    m_rd   = 0;
    idle();

    // Reset with both requesters active.
    rst = 1'b1;
    bus.cpu_req_i  = 1'b1;
    bus.dma_req_i  = 1'b1;
    bus.cpu_we_i   = 4'hF;
    bus.dma_we_i   = 4'hF;
    bus.cpu_addr_i = 24'h000123;
    bus.dma_addr_i = 24'h000456;
    bus.cpu_data_i = 32'h11111111;
    bus.dma_data_i = 32'h22222222;
    step();
    step();
    chk("rst_gnt", {30'b0, s_cgnt, s_dgnt}, 32'h0);
    rst = 1'b0;

    // Contention without burst: DMA forced every ninth cycle.
    for (int i = 0; i < 27; i++) begin
      step();
      if (i == 0) chk("t1_cpu_first", {31'b0, s_cgnt}, 32'h1);
      chk("t3_pattern", {31'b0, s_dgnt},
          {31'b0, (i % 9) == 8});
    end

    // CPU read returning data one cycle later.
    bus.dma_req_i  = 1'b0;
    bus.cpu_we_i   = 4'h0;
    bus.cpu_addr_i = 24'h000040;
    step();
    bus.cpu_req_i  = 1'b0;
    bus.mem_data_i = 32'hDEADBEEF;
    step();
    chk("t2_cpu_rvalid", {31'b0, s_crv}, 32'h1);
    chk("t2_dma_rvalid", {31'b0, s_drv}, 32'h0);
    chk("t2_rdata", s_crdata, 32'hDEADBEEF);

    // Burst lock: 16 DMA grants, one CPU slot, lock resumes.
    bus.cpu_req_i   = 1'b1;
    bus.cpu_we_i    = 4'hF;
    bus.dma_req_i   = 1'b1;
    bus.dma_burst_i = 1'b1;
    bus.dma_we_i    = 4'hF;
    for (int i = 0; i < 45; i++) begin
      step();
      chk("t4_pattern", {31'b0, s_dgnt},
          {31'b0, i >= 8 && ((i - 8) % 17) != 16});
    end

    // Burst dropped mid-lock.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.cpu_req_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      bus.dma_burst_i = (c < 5);
      step();
      bus.cpu_req_i = 1'b1;
      if (c == 5) chk("t5_dma_c5", {31'b0, s_dgnt}, 32'h1);
      if (c == 6) chk("t5_cpu_c6", {31'b0, s_cgnt}, 32'h1);
    end

    // DMA read aborted by reset, then a partial CPU write.
    idle();
    bus.dma_req_i  = 1'b1;
    bus.dma_addr_i = 24'h000080;
    step();
    chk("t6_dma_gnt", {31'b0, s_dgnt}, 32'h1);
    bus.dma_req_i = 1'b0;
    rst = 1'b1;
    step();
    chk("t6_rst_rvalid", {31'b0, s_drv}, 32'h0);
    rst = 1'b0;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 4'b0011;
    bus.cpu_data_i = 32'hCAFEF00D;
    step();
    chk("t6_post_rvalid", {31'b0, s_drv}, 32'h0);
    chk("t6_we", {28'b0, s_we}, 32'h3);
    idle();
    step();
    chk("t6_wr_no_rvalid", {31'b0, s_crv}, 32'h0);

    // Random traffic with sticky burst requests and rare resets.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      bus.cpu_req_i = ($urandom_range(0, 3) != 0);
      bus.dma_req_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0)
        bus.dma_burst_i = $urandom_range(0, 1) == 1;
      bus.cpu_we_i   = $urandom_range(0, 1) == 1 ? 4'h0 : 4'($urandom);
      bus.dma_we_i   = $urandom_range(0, 1) == 1 ? 4'h0 : 4'($urandom);
      bus.cpu_addr_i = 24'($urandom);
      bus.dma_addr_i = 24'($urandom);
      bus.cpu_data_i = $urandom;
      bus.dma_data_i = $urandom;
      bus.mem_data_i = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
